fifo_uart_tx: RTL
=================

// Module: fifo_uart_tx
// PURPOSE
// - Downstream drain stage for the synchronous FIFO: pops one word per frame, serialises it as UART (8N1-style).
// - Drives the FIFO read request from the FIFO empty flag and captures the registered FIFO output.
// - Emits start bit, DATA_WIDTH data bits LSB first, optional parity bit, then STOP_BITS stop bits on tx.
// PARAMETERS
// - DATA_WIDTH    8  word width; must equal the FIFO word width
// - CLKS_PER_BIT  16 clk cycles per serial bit; legal range >=2
// - STOP_BITS     1  stop bits per frame; legal values 1 or 2
// - PARITY_ODD    0  parity sense when PARITY_EN is defined: 0 = even, 1 = odd
// PORTS
// - clk         in   1           single clock; all logic rising-edge
// - rst         in   1           asynchronous reset, active-high
// - FIFO_empty  in   1           FIFO empty flag
// - fifo_data   in   DATA_WIDTH  FIFO registered read data; valid the cycle after a rd_en pulse
// - rd_en       out  1           FIFO read request; registered, exactly one cycle per frame
// - tx          out  1           serial line; idle high
// - busy        out  1           high in every state except IDLE
// - frame_done  out  1           one-cycle pulse in the last cycle of the final stop bit
// BEHAVIOUR
// - Reset (async, immediate):
//   - tx=1, rd_en=0, busy=0, frame_done=0
//   - state=IDLE; bit counter, baud counter and shift register all 0
// - FSM states: IDLE, REQ, LOAD, START, DATA, PARITY (only with PARITY_EN), STOP.
// - IDLE:
//   - If FIFO_empty==0, go to REQ.
//   - FIFO_empty is sampled only in IDLE.
// - REQ:
//   - Exactly 1 cycle, with rd_en=1; the FIFO pops at the edge ending REQ.
//   - Then go to LOAD.
// - LOAD:
//   - Exactly 1 cycle, with rd_en=0.
//   - Capture fifo_data into the shift register at the edge ending LOAD.
//   - Then go to START.
// - Bit states:
//   - START: tx=0 for CLKS_PER_BIT cycles.
//   - DATA: DATA_WIDTH bits, each CLKS_PER_BIT cycles, shift register bit 0 first.
//   - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
// - Baud counter:
//   - Counts 0..CLKS_PER_BIT-1.
//   - Bit state advances when it reaches CLKS_PER_BIT-1, then wraps to 0.
//   - Width = $clog2(CLKS_PER_BIT).
// - Bit counter: width $clog2(DATA_WIDTH+1); cleared on entry to DATA.
// - frame_done: asserted in the final cycle of STOP; the next state is IDLE.
// - Frame length:
//   - REQ to end of STOP = 2 + (1+DATA_WIDTH+P+STOP_BITS)*CLKS_PER_BIT cycles, with P=1 if PARITY_EN else 0.
//   - Back-to-back frames with a non-empty FIFO: 3 extra tx-high cycles between frames (IDLE, REQ, LOAD).
// - tx is a registered output; no combinational path from any input to tx.
// - Only one rd_en per frame, so the block never requests while the FIFO is empty.
//   - FIFO_empty may rise during a frame without effect.
// - Reset mid-frame:
//   - tx returns high at once; any word already popped is discarded.
//   - After release, the block restarts from IDLE.
// CONFIGURATION
// - Macro PARITY_EN:
//   - Defined: a PARITY state of CLKS_PER_BIT cycles follows DATA.
//     - tx = ^word XOR PARITY_ODD.
//     - Frame = start + DATA_WIDTH + parity + stop bits.
//   - Undefined: no PARITY state and no parity logic; DATA goes directly to STOP.
// TESTING
// - Bench config: DATA_WIDTH=8, CLKS_PER_BIT=4, STOP_BITS=1 unless stated.
// - T1 reset:
//   - Stimulus: rst=1 mid-DATA, FIFO holding 2 words.
//   - Expect: tx=1, busy=0, rd_en=0 in the same cycle.
//   - After release: next frame carries the second word.
// - T2 single frame, no PARITY_EN:
//   - Stimulus: push 0xA5.
//   - Expect: rd_en pulse of 1 cycle.
//   - Expect tx bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles; 40 cycles from START entry to IDLE.
//   - Expect frame_done at cycle 40.
// - T3 back-to-back:
//   - Stimulus: push 0x00, 0xFF, 0x3C.
//   - Expect: 3 frames in order, exactly 3 tx-high cycles between the stop bit and the next start bit.
//   - Expect: 3 rd_en pulses total; FIFO_empty=1 after the third pop.
// - T4 PARITY_EN, PARITY_ODD=0:
//   - Stimulus: 0xA5.
//   - Expect: parity bit 0; 44-cycle frame.
//   - Repeat with PARITY_ODD=1 and 0x01: parity bit 0; 0x03: parity bit 1.
// - T5 STOP_BITS=2, CLKS_PER_BIT=2:
//   - Stimulus: 0x81.
//   - Expect: stop high for 4 cycles; frame_done in the 4th cycle.
// - T6 empty FIFO:
//   - Stimulus: FIFO_empty held 1 for 100 cycles.
//   - Expect: rd_en never asserted, tx=1, busy=0 throughout.

Source files
------------

// File: rtl/fifo_uart_tx_if.sv
// FIFO-side bundle for fifo_uart_tx: read request/data from the FIFO plus the serial line and status.
// Handshake: rd_en is a one-cycle pop request issued only after FIFO_empty was seen low; fifo_data is valid the cycle after rd_en.
interface fifo_uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  FIFO_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  rd_en;
    logic                  tx;
    logic                  busy;
    logic                  frame_done;

    modport master (
        input  FIFO_empty,
        input  fifo_data,
        output rd_en,
        output tx,
        output busy,
        output frame_done
    );

    modport slave (
        output FIFO_empty,
        output fifo_data,
        input  rd_en,
        input  tx,
        input  busy,
        input  frame_done
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one word per frame and serialises it as UART (start, data LSB first, stop).
// Optional parity bit after the data bits is enabled by defining the macro PARITY_EN.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic            clk,
    input  logic            rst,
    fifo_uart_tx_if.master  bus,
    output logic [2:0]      dbg_state_o
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_params
        $error("fifo_uart_tx: illegal parameter value");
    end

`ifdef PARITY_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0, REQ = 3'd1, LOAD = 3'd2, START = 3'd3,
        DATA = 3'd4, PARITY = 3'd5, STOP = 3'd6
    } state_e;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0, REQ = 3'd1, LOAD = 3'd2, START = 3'd3,
        DATA = 3'd4, STOP = 3'd6
    } state_e;
`endif

    state_e                state_q, state_d;
    logic [BW-1:0]         baud_q, baud_d;
    logic [CW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  tx_q, tx_d;
    logic                  rd_en_q, rd_en_d;
    logic                  baud_end;
`ifdef PARITY_EN
    logic                  par_q, par_d;
`endif

    assign baud_end = (baud_q == BAUD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            rd_en_q <= 1'b0;
`ifdef PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            rd_en_q <= rd_en_d;
`ifdef PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
`ifdef PARITY_EN
        par_d   = par_q;
`endif
        // Every bit-timed state shares one free-running baud count that wraps at the bit boundary.
        if (state_q == START || state_q == DATA || state_q == STOP
`ifdef PARITY_EN
            || state_q == PARITY
`endif
           ) begin
            baud_d = baud_end ? '0 : baud_q + 1'b1;
        end
        case (state_q)
            IDLE:  if (!bus.FIFO_empty) state_d = REQ;
            REQ:   state_d = LOAD;
            LOAD: begin
                shreg_d = bus.fifo_data;
`ifdef PARITY_EN
                par_d   = (^bus.fifo_data) ^ (PARITY_ODD != 0);
`endif
                baud_d  = '0;
                state_d = START;
            end
            START: if (baud_end) begin
                bit_d   = '0;
                state_d = DATA;
            end
            DATA: if (baud_end) begin
                shreg_d = shreg_q >> 1;
                if (bit_q == DATA_LAST) begin
                    bit_d = '0;
`ifdef PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
`ifdef PARITY_EN
            PARITY: if (baud_end) begin
                bit_d   = '0;
                state_d = STOP;
            end
`endif
            STOP: if (baud_end) begin
                if (bit_q == STOP_LAST) state_d = IDLE;
                else                    bit_d   = bit_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // tx is registered from the upcoming state so the line changes exactly on bit boundaries.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
`ifdef PARITY_EN
            PARITY:  tx_d = par_q;
`endif
            default: tx_d = 1'b1;
        endcase
        rd_en_d = (state_d == REQ);
    end

    assign bus.tx         = tx_q;
    assign bus.rd_en      = rd_en_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.frame_done = (state_q == STOP) && baud_end && (bit_q == STOP_LAST);
    assign dbg_state_o    = state_q;
endmodule
